mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 152 +++++++++++++++
 tb/tb_mult_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: collects eight operand bytes from the host, then drives a
// data_loader through dimension, operand-load and compute phases.
module mult_sequencer #(
    parameter int unsigned MAT_XxX    = 2,
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  ld_data,
    output logic [1:0]  ld_ctrl,
    input  logic [63:0] ld_res,
    output logic [63:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic [7:0]  mat_count
);

    typedef enum logic [2:0] {
        S_FILL,
        S_DIMS,
        S_LOAD,
        S_COMPUTE,
        S_OUT
    } state_t;

    localparam logic [1:0] CTRL_OPER = 2'd0;
    localparam logic [1:0] CTRL_DIM  = 2'd1;
    localparam logic [1:0] CTRL_IDLE = 2'd2;

    localparam logic [7:0] MAT_BYTE  = 8'(MAT_XxX);
    localparam logic [3:0] LAST_DIM  = 4'd3;
    localparam logic [3:0] LAST_LOAD = 4'd7;
    localparam logic [3:0] LAST_CMP  = 4'(RESULT_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  wr_idx_q, wr_idx_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  buf_q [8];
    logic [7:0]  buf_d [8];
    logic [1:0]  ld_ctrl_q, ld_ctrl_d;
    logic [7:0]  ld_data_q, ld_data_d;
    logic [63:0] res_data_q, res_data_d;
    logic        res_valid_q, res_valid_d;
    logic [7:0]  mat_count_q, mat_count_d;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        phase_d     = phase_q;
        buf_d       = buf_q;
        ld_ctrl_d   = ld_ctrl_q;
        ld_data_d   = ld_data_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        mat_count_d = mat_count_q;

        unique case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    buf_d[wr_idx_q] = in_data;
                    wr_idx_d        = wr_idx_q + 3'd1;
                    if (wr_idx_q == 3'd7) begin
                        state_d   = S_DIMS;
                        phase_d   = 4'd0;
                        ld_ctrl_d = CTRL_DIM;
                        ld_data_d = MAT_BYTE;
                    end
                end
            end
            S_DIMS: begin
                if (phase_q == LAST_DIM) begin
                    state_d   = S_LOAD;
                    phase_d   = 4'd0;
                    ld_ctrl_d = CTRL_OPER;
                    ld_data_d = buf_q[0];
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_LOAD: begin
                if (phase_q == LAST_LOAD) begin
                    state_d   = S_COMPUTE;
                    phase_d   = 4'd0;
                    ld_ctrl_d = CTRL_IDLE;
                    ld_data_d = 8'd0;
                end else begin
                    phase_d   = phase_q + 4'd1;
                    ld_data_d = buf_q[3'(phase_q[2:0] + 3'd1)];
                end
            end
            S_COMPUTE: begin
                if (phase_q == LAST_CMP) begin
                    state_d     = S_OUT;
                    phase_d     = 4'd0;
                    res_data_d  = ld_res;
                    res_valid_d = 1'b1;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d     = S_FILL;
                    res_valid_d = 1'b0;
                    mat_count_d = mat_count_q + 8'd1;
                end
            end
            default: begin
                state_d = S_FILL;
                phase_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_FILL;
            wr_idx_q    <= 3'd0;
            phase_q     <= 4'd0;
            for (int i = 0; i < 8; i++) buf_q[i] <= 8'd0;
            ld_ctrl_q   <= CTRL_IDLE;
            ld_data_q   <= 8'd0;
            res_data_q  <= 64'd0;
            res_valid_q <= 1'b0;
            mat_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            phase_q     <= phase_d;
            buf_q       <= buf_d;
            ld_ctrl_q   <= ld_ctrl_d;
            ld_data_q   <= ld_data_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            mat_count_q <= mat_count_d;
        end
    end

    // Held low while in reset so no byte is offered a handshake mid-reset.
    assign in_ready  = RST_N && (state_q == S_FILL);
    assign busy      = (state_q != S_FILL);
    assign ld_ctrl   = ld_ctrl_q;
    assign ld_data   = ld_data_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign mat_count = mat_count_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of fill, loader sequencing, result
// handshake, mid-operation reset, count wrap and latency variants.
module tb_mult_sequencer;

    localparam int         LAT = 2;
    localparam logic [7:0] MAT = 8'd2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [63:0] ld_res = 64'd0;

    logic        in_ready, res_valid, busy;
    logic [7:0]  ld_data, mat_count;
    logic [1:0]  ld_ctrl;
    logic [63:0] res_data;

    logic        r1_in_ready, r1_res_valid, r1_busy;
    logic [7:0]  r1_ld_data, r1_mat_count;
    logic [1:0]  r1_ld_ctrl;
    logic [63:0] r1_res_data;

    logic        r15_in_ready, r15_res_valid, r15_busy;
    logic [7:0]  r15_ld_data, r15_mat_count;
    logic [1:0]  r15_ld_ctrl;
    logic [63:0] r15_res_data;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [7:0]  v [8];

    mult_sequencer u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ld_data(ld_data), .ld_ctrl(ld_ctrl), .ld_res(ld_res),
        .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .mat_count(mat_count)
    );

    mult_sequencer #(.RESULT_LAT(1)) u_lat1 (
        .CLK(CLK), .RST_N(RST_N),
        .in_data(in_data), .in_valid(in_valid), .in_ready(r1_in_ready),
        .ld_data(r1_ld_data), .ld_ctrl(r1_ld_ctrl), .ld_res(ld_res),
        .res_data(r1_res_data), .res_valid(r1_res_valid),
        .res_ready(res_ready), .busy(r1_busy), .mat_count(r1_mat_count)
    );

    mult_sequencer #(.RESULT_LAT(15)) u_lat15 (
        .CLK(CLK), .RST_N(RST_N),
        .in_data(in_data), .in_valid(in_valid), .in_ready(r15_in_ready),
        .ld_data(r15_ld_data), .ld_ctrl(r15_ld_ctrl), .ld_res(ld_res),
        .res_data(r15_res_data), .res_valid(r15_res_valid),
        .res_ready(res_ready), .busy(r15_busy), .mat_count(r15_mat_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ld_res <= {$urandom, $urandom};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input bit held);
        chk("rst_ctrl", ld_ctrl, 2'd2);
        chk("rst_data", ld_data, 8'd0);
        chk("rst_rvld", res_valid, 1'b0);
        chk("rst_rdat", res_data, 64'd0);
        chk("rst_cnt", mat_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", in_ready, held ? 1'b0 : 1'b1);
    endtask

    task automatic run_op(input logic [7:0] b [8], input bit toggle,
                          input int hold, input int abort_at,
                          input bit tied, input bit lat_chk);
        logic [63:0] hist [64];
        logic [63:0] exp;
        int c;
        for (int i = 0; i < 8; i++) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(posedge CLK); #1;
                chk("gap_busy", busy, 1'b0);
            end
            chk("fill_rdy", in_ready, 1'b1);
            chk("fill_ctrl", ld_ctrl, 2'd2);
            in_valid = 1'b1;
            in_data  = b[i];
            @(posedge CLK); #1;
        end
        // Junk offered while busy must never be stored.
        in_data = 8'hEE;
        for (c = 1; c <= 12 + LAT; c++) begin
            hist[c] = ld_res;
            chk("op_busy", busy, 1'b1);
            chk("op_rdy", in_ready, 1'b0);
            chk("op_rvld", res_valid, 1'b0);
            chk("op_cnt", mat_count, exp_cnt);
            if (c <= 4) begin
                chk("dim_ctrl", ld_ctrl, 2'd1);
                chk("dim_data", ld_data, MAT);
            end else if (c <= 12) begin
                chk("ld_ctrl", ld_ctrl, 2'd0);
                chk("ld_data", ld_data, b[c-5]);
            end else begin
                chk("cmp_ctrl", ld_ctrl, 2'd2);
                chk("cmp_data", ld_data, 8'd0);
            end
            if (lat_chk) begin
                chk("lat1_vld", r1_res_valid, c >= 14);
                chk("lat15_vld", r15_res_valid, 1'b0);
            end
            if (c == abort_at) begin
                #2 RST_N = 1'b0;
                #1 check_reset(1'b1);
                in_valid = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
                #1 chk("rel_rdy", in_ready, 1'b1);
                exp_cnt = 8'd0;
                return;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        exp = hist[12 + LAT];
        for (int h = 0; h <= hold; h++) begin
            c = 13 + LAT + h;
            hist[c] = ld_res;
            chk("out_rvld", res_valid, 1'b1);
            chk("out_rdat", res_data, exp);
            chk("out_ctrl", ld_ctrl, 2'd2);
            chk("out_data", ld_data, 8'd0);
            chk("out_rdy", in_ready, 1'b0);
            chk("out_busy", busy, 1'b1);
            chk("out_cnt", mat_count, exp_cnt);
            if (lat_chk) begin
                chk("lat1_vld", r1_res_valid, 1'b1);
                chk("lat15_vld", r15_res_valid, c >= 28);
            end
            if (h < hold) begin
                @(posedge CLK); #1;
            end
        end
        if (lat_chk) begin
            chk("lat1_rdat", r1_res_data, hist[13]);
            chk("lat15_rdat", r15_res_data, hist[27]);
        end
        if (!tied) res_ready = 1'b1;
        @(posedge CLK); #1;
        if (!tied) res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("acc_rvld", res_valid, 1'b0);
        chk("acc_rdy", in_ready, 1'b1);
        chk("acc_busy", busy, 1'b0);
        chk("acc_cnt", mat_count, exp_cnt);
    endtask

    initial begin
        @(posedge CLK); #1;
        check_reset(1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check_reset(1'b0);

        v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_op(v, 1'b0, 20, 0, 1'b0, 1'b1);

        v = '{8'hA1, 8'h00, 8'hFF, 8'h7E, 8'h01, 8'h80, 8'hC3, 8'h3C};
        run_op(v, 1'b1, 0, 0, 1'b0, 1'b0);

        v = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_op(v, 1'b0, 0, 8, 1'b0, 1'b0);

        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_op(v, 1'b0, 3, 0, 1'b0, 1'b0);

        RST_N = 1'b0;
        #1 check_reset(1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_cnt = 8'd0;
        #1;

        res_ready = 1'b1;
        for (int op = 0; op < 256; op++) begin
            for (int i = 0; i < 8; i++) v[i] = 8'(op * 8 + i) ^ 8'h3C;
            run_op(v, 1'b0, 0, 0, 1'b1, 1'b0);
        end
        res_ready = 1'b0;
        chk("wrap_cnt", mat_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
